// File: rtl/alu_pkg.sv
// Shared execute-stage ALU definitions.
// Contents:
//   ALU_* : 3-bit ALU control encodings. The ALU, the control decoder and the
//           multiply/divide sequencer all use these constants.
//   state_t, ST_* : muldiv_sequencer FSM state type and state constants.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_src_mux.sv
// Ownership mux in front of the shared execute-stage ALU.
// Ports:
//   i_alu_own          : 1 selects the sequencer drive, 0 selects the pipeline drive
//   i_pipe_srca/srcb   : pipeline ALU operands
//   i_pipe_ctrl        : pipeline ALU control
//   i_seq_srca/srcb    : sequencer ALU operands
//   i_seq_ctrl         : sequencer ALU control
//   o_srca/o_srcb/o_ctrl : selected ALU drive
module alu_src_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_alu_own,
    input  logic [WIDTH-1:0] i_pipe_srca,
    input  logic [WIDTH-1:0] i_pipe_srcb,
    input  logic [2:0]       i_pipe_ctrl,
    input  logic [WIDTH-1:0] i_seq_srca,
    input  logic [WIDTH-1:0] i_seq_srcb,
    input  logic [2:0]       i_seq_ctrl,
    output logic [WIDTH-1:0] o_srca,
    output logic [WIDTH-1:0] o_srcb,
    output logic [2:0]       o_ctrl
);

    assign o_srca = i_alu_own ? i_seq_srca : i_pipe_srca;
    assign o_srcb = i_alu_own ? i_seq_srcb : i_pipe_srcb;
    assign o_ctrl = i_alu_own ? i_seq_ctrl : i_pipe_ctrl;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer. Borrows the shared execute ALU
// for WIDTH cycles and iterates shift-add (multiply) or restoring
// subtract-shift (divide) steps into a 2*WIDTH-bit HI:LO result.
// Ports:
//   clock, reset_n      : rising-edge clock, synchronous active-low reset
//   start, op           : request (op 0 = MULTU, 1 = DIVU), sampled in IDLE only
//   operand_a/operand_b : multiplicand/dividend and multiplier/divisor
//   ALUResultE          : combinational result of the shared ALU
//   alu_own             : sequencer owns the ALU (RUN)
//   seq_SrcAE/SrcBE/ALUControlE : ALU drive (ALU_ADD and zero operands when not owned)
//   busy                : RUN or DONE, feeds the pipeline stall
//   done                : one-cycle completion pulse
//   hi, lo              : product high/low word, or remainder/quotient
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] ALUResultE,
    output logic             alu_own,
    output logic [WIDTH-1:0] seq_SrcAE,
    output logic [WIDTH-1:0] seq_SrcBE,
    output logic [2:0]       seq_ALUControlE,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_rem;       // partial remainder shifted left by one
    logic             w_carry;     // carry out of hi + B
    logic             w_ge;        // shifted remainder >= divisor
    logic [WIDTH-1:0] w_srca;
    logic [2:0]       w_ctrl;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    assign w_rem   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    // Unsigned wrap of hi + B means a carry out.
    assign w_carry = (ALUResultE < r_hi);
    // The bit shifted out of hi is an implicit 2^WIDTH, which always covers
    // the divisor; otherwise a borrow shows up as the difference exceeding r.
    assign w_ge    = r_hi[WIDTH-1] | ~(ALUResultE > w_rem);

    assign w_srca  = r_op ? w_rem : r_hi;
    assign w_ctrl  = r_op ? ALU_SUB : ALU_ADD;

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op) begin
            w_hi_nxt = w_ge ? ALUResultE : w_rem;
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else if (r_lo[0]) begin
            w_hi_nxt = {w_carry, ALUResultE[WIDTH-1:1]};
            w_lo_nxt = {ALUResultE[0], r_lo[WIDTH-1:1]};
        end else begin
            w_hi_nxt = {1'b0, r_hi[WIDTH-1:1]};
            w_lo_nxt = {r_hi[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_op    <= op;
                        r_b     <= operand_b;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_lo    <= operand_a;
                    end
                end
                ST_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_own = (r_state == ST_RUN);
    assign busy    = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign done    = (r_state == ST_DONE);
    assign hi      = r_hi;
    assign lo      = r_lo;

    // Pipeline side is parked at a harmless ADD of zeros; the real pipeline
    // mux sits outside this block and uses alu_own the same way.
    alu_src_mux #(.WIDTH(WIDTH)) u_src_mux (
        .i_alu_own   (alu_own),
        .i_pipe_srca ('0),
        .i_pipe_srcb ('0),
        .i_pipe_ctrl (ALU_ADD),
        .i_seq_srca  (w_srca),
        .i_seq_srcb  (r_b),
        .i_seq_ctrl  (w_ctrl),
        .o_srca      (seq_SrcAE),
        .o_srcb      (seq_SrcBE),
        .o_ctrl      (seq_ALUControlE)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic         op;
    logic [W-1:0] operand_a, operand_b;
    logic [W-1:0] ALUResultE;
    logic         alu_own, busy, done;
    logic [W-1:0] seq_SrcAE, seq_SrcBE, hi, lo;
    logic [2:0]   seq_ALUControlE;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*W-1:0] sb[$];

    always #5 clock = ~clock;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .ALUResultE(ALUResultE),
        .alu_own(alu_own), .seq_SrcAE(seq_SrcAE), .seq_SrcBE(seq_SrcBE),
        .seq_ALUControlE(seq_ALUControlE), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    // Shared execute-stage ALU
    always_comb begin
        case (seq_ALUControlE)
            ALU_AND: ALUResultE = seq_SrcAE & seq_SrcBE;
            ALU_OR:  ALUResultE = seq_SrcAE | seq_SrcBE;
            ALU_ADD: ALUResultE = seq_SrcAE + seq_SrcBE;
            ALU_SUB: ALUResultE = seq_SrcAE - seq_SrcBE;
            ALU_SLT: ALUResultE = {{(W-1){1'b0}}, $signed(seq_SrcAE) < $signed(seq_SrcBE)};
            default: ALUResultE = '0;
        endcase
    end

    // Scoreboard: every done pulse pops one expected {hi,lo}
    always @(negedge clock) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_done: got hi=%h lo=%h, required no done pulse", hi, lo);
            end else begin
                logic [2*W-1:0] e;
                e = sb.pop_front();
                if ({hi, lo} !== e)
                    $display("FAIL result: got hi=%h lo=%h, required hi=%h lo=%h", hi, lo, e[2*W-1:W], e[W-1:0]);
                else
                    n_pass++;
            end
        end
    end

    function automatic logic [2*W-1:0] model(input logic o, input logic [W-1:0] a, b);
        logic [2*W-1:0] p;
        if (!o) p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        else if (b == 0) p = {a, {W{1'b1}}};
        else p = {a % b, a / b};
        return p;
    endfunction

    // Drives one operation and measures it; optionally retries start in RUN
    // cycle 5 and in DONE with fresh operands.
    task automatic run_op(input logic o, input logic [W-1:0] a, b, input logic [2*W-1:0] exp,
                          input bit inj, output int done_k, output int own_n,
                          output int busy_n, output int done_n, output logic [2:0] ctrl_run);
        done_k = 0; own_n = 0; busy_n = 0; done_n = 0; ctrl_run = 3'bxxx;
        sb.push_back(exp);
        @(negedge clock);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clock);
            if (alu_own) own_n++;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            if (k == 1) ctrl_run = seq_ALUControlE;
            start = inj && (k == 5 || k == 33);
            op = ~o; operand_a = $urandom; operand_b = $urandom;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++; if ({busy, done, alu_own} !== 3'b000) $display("FAIL reset_flags: got %b, required 000", {busy, done, alu_own}); else n_pass++;
        n_checks++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h, required 0", {hi, lo}); else n_pass++;
        n_checks++; if ({seq_SrcAE, seq_SrcBE} !== 64'd0) $display("FAIL reset_src: got %h, required 0", {seq_SrcAE, seq_SrcBE}); else n_pass++;
        n_checks++; if (seq_ALUControlE !== ALU_ADD) $display("FAIL reset_ctrl: got %b, required %b", seq_ALUControlE, ALU_ADD); else n_pass++;
    endtask

    task automatic test_multu();
        int dk, on, bn, dn; logic [2:0] c;
        run_op(1'b0, 32'd6, 32'd3, 64'h0000_0000_0000_0012, 1'b0, dk, on, bn, dn, c);
        n_checks++; if (dk !== 33) $display("FAIL mul_latency: got %0d, required 33", dk); else n_pass++;
        n_checks++; if (on !== 32) $display("FAIL mul_own_cycles: got %0d, required 32", on); else n_pass++;
        n_checks++; if (bn !== 33) $display("FAIL mul_busy_cycles: got %0d, required 33", bn); else n_pass++;
        n_checks++; if (c !== ALU_ADD) $display("FAIL mul_ctrl: got %b, required %b", c, ALU_ADD); else n_pass++;
        n_checks++; if ({hi, lo} !== 64'h12) $display("FAIL mul_hold: got %h, required 12", {hi, lo}); else n_pass++;
        n_checks++; if (seq_ALUControlE !== ALU_ADD) $display("FAIL idle_ctrl: got %b, required %b", seq_ALUControlE, ALU_ADD); else n_pass++;
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, dk, on, bn, dn, c);
        n_checks++; if (dn !== 1) $display("FAIL mul_carry_pulses: got %0d, required 1", dn); else n_pass++;
    endtask

    task automatic test_divu();
        int dk, on, bn, dn; logic [2:0] c;
        run_op(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, dk, on, bn, dn, c);
        n_checks++; if (c !== ALU_SUB) $display("FAIL div_ctrl: got %b, required %b", c, ALU_SUB); else n_pass++;
        n_checks++; if (dk !== 33) $display("FAIL div_latency: got %0d, required 33", dk); else n_pass++;
        run_op(1'b1, 32'h8000_0000, 32'd1, {32'd0, 32'h8000_0000}, 1'b0, dk, on, bn, dn, c);
        n_checks++; if (dn !== 1) $display("FAIL div_msb_pulses: got %0d, required 1", dn); else n_pass++;
    endtask

    task automatic test_divzero();
        int dk, on, bn, dn; logic [2:0] c;
        run_op(1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b0, dk, on, bn, dn, c);
        n_checks++; if (dk !== 33) $display("FAIL div0_latency: got %0d, required 33", dk); else n_pass++;
        n_checks++; if (bn !== 33) $display("FAIL div0_busy_cycles: got %0d, required 33", bn); else n_pass++;
    endtask

    task automatic test_ignore_start();
        int dk, on, bn, dn; logic [2:0] c;
        run_op(1'b0, 32'd6, 32'd3, 64'h12, 1'b1, dk, on, bn, dn, c);
        n_checks++; if (dn !== 1) $display("FAIL ignore_done_pulses: got %0d, required 1", dn); else n_pass++;
        n_checks++; if (bn !== 33) $display("FAIL ignore_busy_cycles: got %0d, required 33", bn); else n_pass++;
        run_op(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, dk, on, bn, dn, c);
        n_checks++; if (dk !== 33) $display("FAIL ignore_div_latency: got %0d, required 33", dk); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int dk, on, bn, dn; logic [2:0] c;
        @(negedge clock);
        start = 1'b1; op = 1'b0; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_checks++; if ({busy, done, alu_own} !== 3'b000) $display("FAIL midreset_flags: got %b, required 000", {busy, done, alu_own}); else n_pass++;
        n_checks++; if ({hi, lo} !== 64'd0) $display("FAIL midreset_hilo: got %h, required 0", {hi, lo}); else n_pass++;
        repeat (3) @(negedge clock);
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset_stays_idle: got %b, required 0", busy); else n_pass++;
        run_op(1'b0, 32'd6, 32'd3, 64'h12, 1'b0, dk, on, bn, dn, c);
        n_checks++; if (dk !== 33) $display("FAIL midreset_rerun_latency: got %0d, required 33", dk); else n_pass++;
    endtask

    task automatic test_random();
        int dk, on, bn, dn; logic [2:0] c;
        logic [W-1:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = (i == 3) ? W'($urandom_range(1, 255)) : $urandom;
            run_op(i[0], a, b, model(i[0], a, b), 1'b0, dk, on, bn, dn, c);
            n_checks++; if (dn !== 1) $display("FAIL random_pulses[%0d]: got %0d, required 1", i, dn); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_divzero();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        repeat (2) @(negedge clock);
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
